// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - access size encodings carried on req_size
//   - FSM state type
//   - default base address of the data-memory window
//   - size_to_bytes: number of RAM byte transfers for a size code
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Illegal size returns 0; such requests never reach ACCESS.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        unique case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            SIZE_W:  n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension (combinational).
//   i_buf      : assembled little-endian load buffer
//   i_size     : access size code (byte / half / word)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_rdata    : extended load result
module load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_buf,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned HALF_WIDTH = 2 * BYTE_WIDTH;

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_buf[BYTE_WIDTH-1];
    assign w_sign_h = ~i_unsigned & i_buf[HALF_WIDTH-1];

    always_comb begin
        o_rdata = i_buf;
        unique case (i_size)
            SIZE_B:  o_rdata = {{(DATA_WIDTH-BYTE_WIDTH){w_sign_b}}, i_buf[BYTE_WIDTH-1:0]};
            SIZE_H:  o_rdata = {{(DATA_WIDTH-HALF_WIDTH){w_sign_h}}, i_buf[HALF_WIDTH-1:0]};
            default: o_rdata = i_buf;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the CPU datapath and a byte-wide data RAM.
// One request at a time; each access is split into 1/2/4 byte RAM
// transactions in little-endian order, then answered on a valid/ready
// response channel.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_req_* / o_req_ready     : request channel (we, size, unsigned, addr, wdata)
//   o_resp_* / i_resp_ready   : response channel (err, rdata)
//   o_mem_addr/we/wdata       : RAM byte port outputs
//   i_mem_rdata               : RAM asynchronous read byte at o_mem_addr
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned          ADDRESS_WIDTH = 12,
    parameter int unsigned          DATA_WIDTH    = 32,
    parameter int unsigned          BYTE_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] DMEM_BASE    = DMEM_BASE_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [1:0]               i_req_size,
    input  logic                     i_req_unsigned,
    input  logic [DATA_WIDTH-1:0]    i_req_addr,
    input  logic [DATA_WIDTH-1:0]    i_req_wdata,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready,
    output logic                     o_resp_err,
    output logic [DATA_WIDTH-1:0]    o_resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic                     o_mem_we,
    output logic [BYTE_WIDTH-1:0]    o_mem_wdata,
    input  logic [BYTE_WIDTH-1:0]    i_mem_rdata
);

    lsu_state_e r_state;
    lsu_state_e w_state_next;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [1:0]               r_size;
    logic                     r_we;
    logic                     r_unsigned;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_buf;
    logic                     r_err;
    logic [1:0]               r_cnt;

    logic [DATA_WIDTH-1:0]    w_offset;
    logic                     w_in_window;
    logic                     w_req_err;
    logic                     w_accept;
    logic                     w_last;
    logic [DATA_WIDTH-1:0]    w_ext_data;

    // Below-base addresses wrap to a huge offset, so one upper-bits test
    // covers both ends of the window.
    assign w_offset    = i_req_addr - DMEM_BASE;
    assign w_in_window = (w_offset >> ADDRESS_WIDTH) == '0;

    always_comb begin
        w_req_err = ~w_in_window;
        unique case (i_req_size)
            SIZE_B:  ;
            SIZE_H:  w_req_err = w_req_err | i_req_addr[0];
            SIZE_W:  w_req_err = w_req_err | (|i_req_addr[1:0]);
            default: w_req_err = 1'b1;
        endcase
    end

    assign w_accept = (r_state == IDLE) && i_req_valid;
    assign w_last   = {1'b0, r_cnt} == (size_to_bytes(r_size) - 3'd1);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_state_next = w_req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (w_last) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, byte counter and load buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_size     <= SIZE_B;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_addr     <= w_offset[ADDRESS_WIDTH-1:0];
            r_size     <= i_req_size;
            r_we       <= i_req_we;
            r_unsigned <= i_req_unsigned;
            r_wdata    <= i_req_wdata;
            r_buf      <= '0;
            r_err      <= w_req_err;
            r_cnt      <= '0;
        end else if (r_state == ACCESS) begin
            if (!r_we) begin
                r_buf[r_cnt*BYTE_WIDTH +: BYTE_WIDTH] <= i_mem_rdata;
            end
            r_cnt <= r_cnt + 2'd1;
        end
    end

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_load_extend (
        .i_buf      (r_buf),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_rdata    (w_ext_data)
    );

    // Outputs decoded from the state register and latched request only
    always_comb begin
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_err   = 1'b0;
        o_resp_rdata = '0;
        o_mem_addr   = '0;
        o_mem_we     = 1'b0;
        o_mem_wdata  = '0;
        unique case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
            end
            ACCESS: begin
                o_mem_addr  = r_addr + ADDRESS_WIDTH'(r_cnt);
                o_mem_we    = r_we;
                o_mem_wdata = r_wdata[r_cnt*BYTE_WIDTH +: BYTE_WIDTH];
            end
            RESP: begin
                o_resp_valid = 1'b1;
                o_resp_err   = r_err;
                if (!r_err && !r_we) begin
                    o_resp_rdata = w_ext_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: table of request vectors with a
// response scoreboard, plus hand-written backpressure, reset-abort and
// back-to-back sequences. A byte-array RAM model sits on the memory port.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    data_mem_lsu dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_err     (resp_err),
        .o_resp_rdata   (resp_rdata),
        .o_mem_addr     (mem_addr),
        .o_mem_we       (mem_we),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    // RAM model with a log of every byte write
    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    logic [7:0]  ram [0:4095];
    logic        ram_clear;
    logic [31:0] cyc = 0;
    wr_t         wlog[$];

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_clear) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
        end
    end

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Pops the scoreboard head and compares it against the response on the bus
    task automatic score(input string tag);
        resp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " resp_err"}, {31'd0, resp_err}, {31'd0, e.err});
            check({tag, " resp_rdata"}, resp_rdata, e.rdata);
        end
    endtask

    // Latency counts edges from the accept edge (inclusive) to resp_valid
    task automatic run_vec(input int idx, input vec_t v);
        int    n;
        int    lat;
        int    exp_lat;
        int    exp_wr;
        string tag;
        tag     = $sformatf("v%0d", idx);
        n       = nbytes_of(v.size);
        exp_lat = v.err ? 1 : n + 1;
        exp_wr  = (v.we && !v.err) ? n : 0;
        wlog.delete();
        @(negedge clk);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        resp_ready = 1'b1;
        drive(v.we, v.size, v.uns, v.addr, v.wdata);
        exp_q.push_back('{err: v.err, rdata: v.rdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        if (resp_valid) score(tag);
        else void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        check({tag, " idle_after"}, {30'd0, resp_valid, req_ready}, 32'd1);
        check({tag, " n_writes"}, wlog.size(), exp_wr);
        if (wlog.size() == exp_wr) begin
            for (int k = 0; k < exp_wr; k++) begin
                check($sformatf("%s wr%0d addr", tag, k), {20'd0, wlog[k].addr},
                      (v.addr - 32'h1000) + k);
                check($sformatf("%s wr%0d data", tag, k), {24'd0, wlog[k].data},
                      (v.wdata >> (8 * k)) & 32'hFF);
                if (k > 0) check($sformatf("%s wr%0d cycle", tag, k), wlog[k].cyc,
                                 wlog[k-1].cyc + 1);
            end
        end
    endtask

    vec_t vecs[18];

    initial begin
        int    lat;
        int    edges;
        logic  rdy;
        logic  seen;

        //            we    size   uns   addr          wdata         err   rdata
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1007, 32'h0,         1'b0, 32'hFFFF_FFDE};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1007, 32'h0,         1'b0, 32'h0000_00DE};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1006, 32'h0,         1'b0, 32'hFFFF_DEAD};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_1004, 32'h0,         1'b0, 32'h0000_BEEF};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 32'hFFFF_FFEF};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_1008, 32'hABCD_1234, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_100B, 32'h5566_7777, 1'b0, 32'h0000_0000};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'h0,         1'b0, 32'h7700_1234};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_100A, 32'h0,         1'b0, 32'h0000_7700};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0,         1'b1, 32'h0000_0000};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_1005, 32'h0000_FFFF, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h0000_2000, 32'h0000_00AA, 1'b1, 32'h0000_0000};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h0000_0FFF, 32'h0000_00AA, 1'b1, 32'h0000_0000};
        vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h0000_1004, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0102_0304, 1'b0, 32'h0000_0000};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,         1'b0, 32'h0102_0304};

        rst_n      = 1'b0;
        ram_clear  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_unsigned = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_err", {31'd0, resp_err}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset mem_addr", {20'd0, mem_addr}, 32'd0);
        check("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        @(negedge clk);
        ram_clear = 1'b0;
        rst_n     = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // Backpressure: response held while a second request is offered
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0);
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", lat, 5);
        score("bp");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 1'b1, 32'h0000_1005, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d valid", c), {31'd0, resp_valid}, 32'd1);
            check($sformatf("bp hold%0d rdata", c), resp_rdata, 32'hDEAD_BEEF);
            check($sformatf("bp hold%0d req_ready", c), {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp release valid", {31'd0, resp_valid}, 32'd0);
        check("bp release ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp no_accept ready", {31'd0, req_ready}, 32'd1);
        check("bp no_accept valid", {31'd0, resp_valid}, 32'd0);

        // Reset in the middle of a word store: two bytes land, no response
        wlog.delete();
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h0000_1010, 32'h1122_3344);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst after valid", {31'd0, resp_valid}, 32'd0);
        check("rst after ready", {31'd0, req_ready}, 32'd1);
        check("rst writes", wlog.size(), 2);
        check("rst ram010", {24'd0, ram[12'h010]}, 32'h44);
        check("rst ram011", {24'd0, ram[12'h011]}, 32'h33);
        check("rst ram012", {24'd0, ram[12'h012]}, 32'h00);
        check("rst ram013", {24'd0, ram[12'h013]}, 32'h00);

        // Back-to-back: byte store then byte load at the top of the window
        @(negedge clk);
        resp_ready = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 32'h0000_1FFF, 32'h0000_005A);
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 1'b1, 32'h0000_1FFF, 32'h0);
        exp_q.push_back('{err: 1'b0, rdata: 32'h0000_005A});
        edges = 0;
        rdy   = 1'b0;
        seen  = 1'b0;
        while (!rdy && edges < 20) begin
            @(negedge clk);
            rdy = req_ready;
            if (resp_valid && !seen) begin
                seen = 1'b1;
                score("b2b store");
            end
            @(posedge clk);
            #1;
            edges++;
        end
        req_valid = 1'b0;
        check("b2b accept_edge", edges, 3);
        check("b2b store_resp_seen", {31'd0, seen}, 32'd1);
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b load latency", lat, 2);
        score("b2b load");
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
